// File: rtl/spi_flash_reader.sv
// SPI mode-0 burst reader: issues READ (0x03) + 24-bit address, then streams
// the returned bytes out on a valid/ready byte port with backpressure.
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        rvalid,
  input  logic        rready,
  output logic        done,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {
    IDLE, SHIFT_CMD, SHIFT_ADDR, SHIFT_DATA, STALL, GAP
  } state_t;

  localparam logic [7:0] READ_CMD = 8'h03;
  localparam logic [7:0] HP_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state;
  logic [7:0]  hp_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic [8:0]  byte_cnt;
  logic [31:0] tx_sh;
  logic [6:0]  rx_sh;
  logic [7:0]  hold;

  logic       slot;
  logic       consume;
  logic [7:0] rx_byte;
  logic       data_rise;
  logic       byte_done;
  logic       stall_release;
  logic       load;
  logic [7:0] load_data;

  // Byte port: a byte moves when rvalid & rready are both high at a clk edge.
  // rvalid stays high across a consume if a new byte is loaded in that cycle.
  always_comb begin
    slot          = (hp_cnt == HP_LAST);
    consume       = rvalid & rready;
    rx_byte       = {rx_sh, flash_io1};
    data_rise     = (state == SHIFT_DATA) && slot && !flash_clk && (byte_cnt != 9'd0);
    byte_done     = data_rise && (bit_cnt == 5'd7);
    stall_release = (state == STALL) && consume;
    load          = en && ((byte_done && (!rvalid || rready)) || stall_release);
    load_data     = stall_release ? hold : rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hp_cnt    <= 8'd0;
      gap_cnt   <= 8'd0;
      bit_cnt   <= 5'd0;
      byte_cnt  <= 9'd0;
      tx_sh     <= 32'd0;
      rx_sh     <= 7'd0;
      hold      <= 8'd0;
      busy      <= 1'b0;
      rdata     <= 8'd0;
      rvalid    <= 1'b0;
      done      <= 1'b0;
      flash_csb <= 1'b1;
      flash_clk <= 1'b0;
      flash_io0 <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rdata  <= load_data;
        rvalid <= 1'b1;
      end else if (consume) begin
        rvalid <= 1'b0;
      end

      if (state != IDLE && state != GAP && !en) begin
        // Abort: release the bus at once; any pending rdata is left to drain.
        flash_csb <= 1'b1;
        flash_clk <= 1'b0;
        flash_io0 <= 1'b0;
        hp_cnt    <= 8'd0;
        bit_cnt   <= 5'd0;
        byte_cnt  <= 9'd0;
        gap_cnt   <= 8'd0;
        state     <= GAP;
      end else begin
        case (state)
          IDLE: begin
            if (en && start) begin
              tx_sh     <= {READ_CMD, addr};
              byte_cnt  <= (len == 8'd0) ? 9'd256 : {1'b0, len};
              flash_csb <= 1'b0;
              flash_clk <= 1'b0;
              flash_io0 <= READ_CMD[7];
              hp_cnt    <= 8'd0;
              bit_cnt   <= 5'd0;
              busy      <= 1'b1;
              state     <= SHIFT_CMD;
            end
          end

          SHIFT_CMD, SHIFT_ADDR: begin
            if (slot) begin
              hp_cnt <= 8'd0;
              if (!flash_clk) begin
                flash_clk <= 1'b1;
                if (state == SHIFT_CMD && bit_cnt == 5'd7) begin
                  bit_cnt <= 5'd0;
                  state   <= SHIFT_ADDR;
                end else if (state == SHIFT_ADDR && bit_cnt == 5'd23) begin
                  bit_cnt <= 5'd0;
                  state   <= SHIFT_DATA;
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                end
              end else begin
                flash_clk <= 1'b0;
                tx_sh     <= tx_sh << 1;
                flash_io0 <= tx_sh[30];
              end
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          SHIFT_DATA: begin
            if (slot) begin
              hp_cnt <= 8'd0;
              if (byte_cnt == 9'd0) begin
                // Last byte delivered: this slot closes the burst.
                flash_clk <= 1'b0;
                flash_csb <= 1'b1;
                flash_io0 <= 1'b0;
                done      <= 1'b1;
                gap_cnt   <= 8'd0;
                state     <= GAP;
              end else if (!flash_clk) begin
                flash_clk <= 1'b1;
                rx_sh     <= rx_byte[6:0];
                if (bit_cnt == 5'd7) begin
                  bit_cnt <= 5'd0;
                  if (!rvalid || rready) begin
                    byte_cnt <= byte_cnt - 9'd1;
                  end else begin
                    hold  <= rx_byte;
                    state <= STALL;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                end
              end else begin
                flash_clk <= 1'b0;
                flash_io0 <= 1'b0;
              end
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          STALL: begin
            // Finish the high phase of the last bit, then park SCK low.
            if (flash_clk) begin
              if (slot) begin
                flash_clk <= 1'b0;
                hp_cnt    <= 8'd0;
              end else begin
                hp_cnt <= hp_cnt + 8'd1;
              end
            end
            if (consume) begin
              byte_cnt <= byte_cnt - 9'd1;
              state    <= SHIFT_DATA;
            end
          end

          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= 8'd0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) share one
// behavioural SPI NOR flash through a select mux; bursts are scored byte by byte.
module tb_spi_flash_reader;

  localparam int CS_GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, start, rready, sel;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        start0, start1;
  logic        busy0, rvalid0, done0, csb0, sck0, mosi0;
  logic        busy1, rvalid1, done1, csb1, sck1, mosi1;
  logic [7:0]  rdata0, rdata1;
  logic        f_io1;
  logic        f_busy, f_rvalid, f_done, f_csb, f_clk, f_io0;
  logic [7:0]  f_rdata;

  assign start0   = start & ~sel;
  assign start1   = start & sel;
  assign f_busy   = sel ? busy1   : busy0;
  assign f_rvalid = sel ? rvalid1 : rvalid0;
  assign f_rdata  = sel ? rdata1  : rdata0;
  assign f_done   = sel ? done1   : done0;
  assign f_csb    = sel ? csb1    : csb0;
  assign f_clk    = sel ? sck1    : sck0;
  assign f_io0    = sel ? mosi1   : mosi0;

  spi_flash_reader #(.CLK_DIV(2), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start0), .addr(addr), .len(len),
    .busy(busy0), .rdata(rdata0), .rvalid(rvalid0), .rready(rready), .done(done0),
    .flash_csb(csb0), .flash_clk(sck0), .flash_io0(mosi0), .flash_io1(f_io1)
  );

  spi_flash_reader #(.CLK_DIV(1), .CS_GAP(CS_GAP)) dut1 (
    .clk(clk), .rst(rst), .en(en), .start(start1), .addr(addr), .len(len),
    .busy(busy1), .rdata(rdata1), .rvalid(rvalid1), .rready(rready), .done(done1),
    .flash_csb(csb1), .flash_clk(sck1), .flash_io0(mosi1), .flash_io1(f_io1)
  );

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    bit          div1;
    int          exp_rises;
    int          exp_bytes;
    logic [7:0]  exp_b0;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  bit sb_on = 1'b0;
  int rx_cnt, done_cnt, done_csb_bad;
  logic [7:0] first_rx;
  logic prev_csb = 1'b1;

  int cyc = 0;
  int rises, csb_falls, data_bad, min_per, max_per, last_rise;
  logic [31:0] mosi_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000123: mem_byte = 8'hAA;
      24'h000124: mem_byte = 8'h55;
      24'h000125: mem_byte = 8'h0F;
      24'h000126: mem_byte = 8'hF0;
      default:    mem_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Flash model: decodes command/address from MOSI, shifts data on SCK falls.
  initial begin
    rises = 0; csb_falls = 0; data_bad = 0; min_per = 1000000; max_per = 0;
    last_rise = 0; mosi_word = 32'd0; f_io1 = 1'b0;
  end

  always @(negedge f_csb) begin
    csb_falls++;
    rises = 0; mosi_word = 32'd0; f_io1 = 1'b0; data_bad = 0;
    min_per = 1000000; max_per = 0;
  end

  always @(posedge f_clk) begin
    if (f_csb === 1'b0) begin
      if (rises > 0) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
      if (rises < 32) mosi_word = {mosi_word[30:0], f_io0};
      else if (f_io0 !== 1'b0) data_bad++;
      rises++;
    end
  end

  always @(negedge f_clk) begin : miso_drive
    int d;
    logic [7:0] b;
    if (f_csb === 1'b0 && rises >= 32) begin
      d = rises - 32;
      b = mem_byte(mosi_word[23:0] + 24'(d / 8));
      f_io1 = b[7 - (d % 8)];
    end
  end

  // Scoreboard and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_on && !rst && f_rvalid && rready) begin
      if (rx_cnt == 0) first_rx = f_rdata;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_extra: got unexpected byte 0x%0h, expected none", f_rdata);
      end else begin
        check("rdata", {24'd0, f_rdata}, {24'd0, exp_q.pop_front()});
      end
    end
    if (f_done === 1'b1) begin
      done_cnt++;
      if (!(f_csb === 1'b1 && prev_csb === 1'b0)) done_csb_bad++;
    end
    prev_csb = f_csb;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [7:0] l);
    step();
    addr  = a;
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done_gap(input string tag);
    int n, g;
    n = 0;
    while (f_done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, (n < 20000)}, 32'd1);
    g = 0;
    while (f_busy === 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_gap_cycles"}, g, CS_GAP);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int per;
    per = v.div1 ? 2 : 4;
    sel = v.div1;
    rready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < v.exp_bytes; i++) exp_q.push_back(mem_byte(v.addr + 24'(i)));
    rx_cnt = 0; done_cnt = 0; done_csb_bad = 0; first_rx = 8'h00;
    sb_on = 1'b1;
    pulse_start(v.addr, v.len);
    wait_done_gap(tag);
    check({tag, "_sck_rises"}, rises, v.exp_rises);
    check({tag, "_mosi"}, mosi_word, {8'h03, v.addr});
    check({tag, "_bytes"}, rx_cnt, v.exp_bytes);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_first_byte"}, {24'd0, first_rx}, {24'd0, v.exp_b0});
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_with_csb"}, done_csb_bad, 0);
    check({tag, "_period_min"}, min_per, per);
    check({tag, "_period_max"}, max_per, per);
    check({tag, "_mosi_data_zero"}, data_bad, 0);
    sb_on = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t restart;
    int n, g;

    vecs[0] = '{addr: 24'h000123, len: 8'd4, div1: 1'b0, exp_rises: 64,   exp_bytes: 4,   exp_b0: 8'hAA};
    vecs[1] = '{addr: 24'hFFFFFE, len: 8'd3, div1: 1'b0, exp_rises: 56,   exp_bytes: 3,   exp_b0: 8'hC2};
    vecs[2] = '{addr: 24'h0ABCDE, len: 8'd1, div1: 1'b1, exp_rises: 40,   exp_bytes: 1,   exp_b0: 8'h54};
    vecs[3] = '{addr: 24'h000000, len: 8'd0, div1: 1'b0, exp_rises: 2080, exp_bytes: 256, exp_b0: 8'h3C};
    restart = '{addr: 24'h000125, len: 8'd2, div1: 1'b0, exp_rises: 48,   exp_bytes: 2,   exp_b0: 8'h0F};

    rst = 1'b1; en = 1'b1; start = 1'b0; rready = 1'b1; sel = 1'b0;
    addr = 24'd0; len = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_csb", {31'd0, csb0}, 32'd1);
    check("rst_sck", {31'd0, sck0}, 32'd0);
    check("rst_mosi", {31'd0, mosi0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid0}, 32'd0);
    check("rst_rdata", {24'd0, rdata0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_csb_div1", {31'd0, csb1}, 32'd1);
    step();
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: second byte parks in STALL until rready returns.
    sel = 1'b0; rready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mem_byte(24'h000200 + 24'(i)));
    rx_cnt = 0; done_cnt = 0; sb_on = 1'b1;
    pulse_start(24'h000200, 8'd3);
    n = 0;
    while (f_rvalid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_rvalid", {31'd0, (n < 2000)}, 32'd1);
    repeat (199) @(negedge clk);
    check("bp_sck_low", {31'd0, f_clk}, 32'd0);
    check("bp_csb_low", {31'd0, f_csb}, 32'd0);
    check("bp_rises_frozen", rises, 48);
    check("bp_rvalid_held", {31'd0, f_rvalid}, 32'd1);
    step();
    rready = 1'b1;
    wait_done_gap("bp");
    check("bp_bytes", rx_cnt, 3);
    check("bp_leftover", exp_q.size(), 0);
    check("bp_done_count", done_cnt, 1);
    sb_on = 1'b0;

    // Abort after 10 address bits.
    sel = 1'b0; done_cnt = 0;
    pulse_start(24'h012345, 8'd2);
    n = 0;
    while (rises < 18 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_addr", {31'd0, (n < 1000)}, 32'd1);
    check("abort_csb_before", {31'd0, f_csb}, 32'd0);
    step();
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_csb_high", {31'd0, f_csb}, 32'd1);
    check("abort_sck_low", {31'd0, f_clk}, 32'd0);
    check("abort_rises", rises, 18);
    g = 0;
    while (f_busy === 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("abort_gap_cycles", g, CS_GAP);
    check("abort_no_done", done_cnt, 0);
    step();
    en = 1'b1;
    run_vec(restart, "restart");

    // CLK_DIV=1 with a second start while busy.
    sel = 1'b1; rready = 1'b1;
    exp_q.delete();
    exp_q.push_back(mem_byte(24'h000040));
    exp_q.push_back(mem_byte(24'h000041));
    rx_cnt = 0; done_cnt = 0; csb_falls = 0; sb_on = 1'b1;
    pulse_start(24'h000040, 8'd2);
    repeat (5) step();
    addr = 24'h0000F0; len = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done_gap("busy_start");
    check("busy_start_csb_falls", csb_falls, 1);
    check("busy_start_mosi", mosi_word, 32'h03000040);
    check("busy_start_rises", rises, 48);
    check("busy_start_bytes", rx_cnt, 2);
    check("busy_start_leftover", exp_q.size(), 0);
    check("busy_start_done", done_cnt, 1);
    check("busy_start_period", max_per, 2);
    sb_on = 1'b0;
    repeat (2) step();

    // Reset in SHIFT_DATA with a byte pending and start in the reset cycle.
    sel = 1'b0; rready = 1'b0;
    pulse_start(24'h000300, 8'd4);
    n = 0;
    while (rises < 41 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reach_data", {31'd0, (n < 1000)}, 32'd1);
    check("rstmid_rvalid_before", {31'd0, f_rvalid}, 32'd1);
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rstmid_csb", {31'd0, f_csb}, 32'd1);
    check("rstmid_sck", {31'd0, f_clk}, 32'd0);
    check("rstmid_rvalid", {31'd0, f_rvalid}, 32'd0);
    check("rstmid_busy", {31'd0, f_busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("rstmid_start_ignored_busy", {31'd0, f_busy}, 32'd0);
    check("rstmid_start_ignored_csb", {31'd0, f_csb}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
